// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite types: response codes and the write/read FSM state encodings.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_lite_reg_array.sv
// NUM_REGS x DATA_W register storage with a byte-enable write port and a
// registered read port. A read of an unmapped address returns zero.
module axi_lite_reg_array #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we,
  input  logic [IDX_W-1:0]    i_widx,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wbe,
  input  logic                i_re,
  input  logic [IDX_W-1:0]    i_ridx,
  input  logic                i_rhit,
  output logic [DATA_W-1:0]   o_rdata
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic [DATA_W-1:0] r_rdata;

  // Byte-lane writes; reset clears the whole bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (i_wbe[b]) r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Read data is captured on the read request edge and held until the next one,
  // so a same-edge write is not visible in this read.
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= i_rhit ? r_mem[i_ridx] : '0;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// AXI-lite slave terminating AW/W/B/AR/R into a register bank. Write and read
// paths are independent FSMs; every output is driven straight from a flop.
module axi_lite_regfile_slave
  import axi_lite_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 32,
  parameter int                 NUM_REGS  = 16,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   write_addr,
  input  logic                write_addr_valid,
  output logic                write_addr_ready,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W/8-1:0] write_strb,
  input  logic                write_data_valid,
  output logic                write_data_ready,
  output logic [1:0]          write_resp,
  output logic                write_resp_valid,
  input  logic                write_resp_ready,
  input  logic [ADDR_W-1:0]   read_addr,
  input  logic                read_addr_valid,
  output logic                read_addr_ready,
  output logic [DATA_W-1:0]   read_data,
  output logic [1:0]          read_resp,
  output logic                read_data_valid,
  input  logic                read_data_ready
);

  localparam int                BYTES = DATA_W / 8;
  localparam int                LSB   = $clog2(BYTES);
  localparam int                IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(NUM_REGS * BYTES);

  function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (off < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return off[LSB +: IDX_W];
  endfunction

  wr_state_t         r_wstate;
  rd_state_t         r_rstate;
  logic              r_aw_have, r_w_have;
  logic [ADDR_W-1:0] r_awaddr;
  logic [DATA_W-1:0] r_wdata;
  logic [BYTES-1:0]  r_wstrb;
  logic              r_awready, r_wready, r_bvalid;
  resp_t             r_bresp;
  logic              r_arready, r_rvalid;
  resp_t             r_rresp;

  logic              w_aw_fire, w_w_fire, w_ar_fire, w_commit, w_wr_hit;
  logic [ADDR_W-1:0] w_awaddr;
  logic [DATA_W-1:0] w_wdata;
  logic [BYTES-1:0]  w_wstrb;

  assign w_aw_fire = write_addr_valid && r_awready;
  assign w_w_fire  = write_data_valid && r_wready;
  assign w_ar_fire = read_addr_valid  && r_arready;

  // A channel arriving in the commit cycle is used directly, otherwise the latched copy.
  assign w_awaddr  = w_aw_fire ? write_addr : r_awaddr;
  assign w_wdata   = w_w_fire  ? write_data : r_wdata;
  assign w_wstrb   = w_w_fire  ? write_strb : r_wstrb;
  assign w_commit  = (r_wstate == W_IDLE) && (r_aw_have || w_aw_fire) && (r_w_have || w_w_fire);
  assign w_wr_hit  = addr_hit(w_awaddr);

  // Write FSM: latch AW and W independently, commit when both are held, then hold B.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_aw_have <= 1'b0;
      r_w_have  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_commit) begin
            r_wstate  <= W_RESP;
            r_aw_have <= 1'b0;
            r_w_have  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
          end else begin
            if (w_aw_fire) begin
              r_aw_have <= 1'b1;
              r_awaddr  <= write_addr;
            end
            if (w_w_fire) begin
              r_w_have <= 1'b1;
              r_wdata  <= write_data;
              r_wstrb  <= write_strb;
            end
            r_awready <= !(r_aw_have || w_aw_fire);
            r_wready  <= !(r_w_have  || w_w_fire);
          end
        end
        W_RESP: begin
          if (write_resp_ready) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM: accept AR, present R one cycle later and hold it until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_fire) begin
            r_rstate  <= R_DATA;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rresp   <= addr_hit(read_addr) ? RESP_OKAY : RESP_SLVERR;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (read_data_ready) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  axi_lite_reg_array #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regs (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_commit && w_wr_hit),
    .i_widx  (addr_idx(w_awaddr)),
    .i_wdata (w_wdata),
    .i_wbe   (w_wstrb),
    .i_re    (w_ar_fire),
    .i_ridx  (addr_idx(read_addr)),
    .i_rhit  (addr_hit(read_addr)),
    .o_rdata (read_data)
  );

  assign write_addr_ready = r_awready;
  assign write_data_ready = r_wready;
  assign write_resp       = r_bresp;
  assign write_resp_valid = r_bvalid;
  assign read_addr_ready  = r_arready;
  assign read_resp        = r_rresp;
  assign read_data_valid  = r_rvalid;

endmodule

// File: doc/axi_lite_regfile_slave.md
Name: axi_lite_regfile_slave

Overview:
Parametrised AXI-lite slave terminating all five channels (AW, W, B, AR, R) into an internal register array. It is the successor to the current four-channel interface and adds:
- a write-response channel
- byte write strobes
- response codes
- configurable data width, address width and register count
It sits behind the AXI-lite master and provides a configuration/status register bank.

Parameters:
DATA_W, 32, data bus width in bits; must be 32 or 64
ADDR_W, 32, address bus width in bits
NUM_REGS, 16, number of DATA_W-wide registers; must be a power of two, at least 2
BASE_ADDR, 0, byte address of register 0; must be aligned to NUM_REGS*DATA_W/8

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
write_addr  input  ADDR_W  AW address
write_addr_valid  input  1  AW valid
write_addr_ready  output  1  AW ready
write_data  input  DATA_W  W data
write_strb  input  DATA_W/8  W byte strobes
write_data_valid  input  1  W valid
write_data_ready  output  1  W ready
write_resp  output  2  B response
write_resp_valid  output  1  B valid
write_resp_ready  input  1  B ready
read_addr  input  ADDR_W  AR address
read_addr_valid  input  1  AR valid
read_addr_ready  output  1  AR ready
read_data  output  DATA_W  R data
read_resp  output  2  R response
read_data_valid  output  1  R valid
read_data_ready  input  1  R ready

Behaviour:
Clocking and reset
- One clock, clk. Reset rst is synchronous and active-high.
- While rst is high at an edge: all outputs go to 0 (readies, valids, data, resp) and all registers clear to 0.
- Readies rise on the first edge with rst low.
- rst mid-transaction aborts everything. Partially captured AW/W are discarded, pending B/R valids drop, and no response is ever issued for aborted transfers.

Address decode
- offset = addr - BASE_ADDR.
- index = offset >> log2(DATA_W/8). The low log2(DATA_W/8) bits are ignored; misaligned addresses are not an error.
- In range: offset < NUM_REGS*DATA_W/8, and addr >= BASE_ADDR.
- Response codes: OKAY = 2'b00 in range; SLVERR = 2'b10 out of range.

Write FSM: states W_IDLE, W_RESP
- W_IDLE:
  - write_addr_ready = 1 until AW is captured; write_data_ready = 1 until W is captured.
  - AW and W may arrive in either order or in the same cycle; each is latched on its own handshake.
  - The cycle in which the second of the two is captured (or both together) is the commit edge. At that edge, each byte lane with strobe = 1 is written if in range; out-of-range writes are dropped. Then go to W_RESP.
- W_RESP:
  - write_resp_valid = 1 and write_resp holds the code, starting the cycle after the commit edge.
  - Both write readies are 0.
  - write_resp and write_resp_valid stay stable until write_resp_ready is high; then return to W_IDLE.
  - The next AW/W can be accepted the cycle after B completes.
- Strobe of all zeros: no register change, response still OKAY (or SLVERR if out of range).

Read FSM: states R_IDLE, R_DATA
- R_IDLE: read_addr_ready = 1. On AR handshake, register read_data (0 if out of range) and read_resp, then go to R_DATA.
- R_DATA:
  - read_data_valid = 1, starting the cycle after the AR handshake (latency 1).
  - read_addr_ready = 0.
  - read_data and read_resp stay stable until read_data_ready is high; then return to R_IDLE.

Concurrency and widths
- Read and write paths are independent and may be active concurrently.
- AR handshake on the same edge as a write commit to the same register returns the old value (registers and read data are both sampled at that edge).
- No combinational path from any input to any ready output; all outputs are registered.

Decomposition:
- Package axi_lite_pkg:
  - resp_t (2-bit) with RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - wr_state_t {W_IDLE, W_RESP}
  - rd_state_t {R_IDLE, R_DATA}
- One sub-module, axi_lite_reg_array: NUM_REGS x DATA_W storage with byte-enable write port and synchronous read port. The top holds both FSMs and the decode.

Test Plan:
Defaults DATA_W=32, NUM_REGS=16, BASE_ADDR=0.
- Write 0xDEADBEEF to 0x08 with strb 4'hF, AW and W in the same cycle -> write_resp_valid next cycle, write_resp 2'b00. Then read 0x08 -> read_data_valid one cycle after AR handshake, read_data 0xDEADBEEF, read_resp 2'b00.
- W presented at cycle n, AW at cycle n+3 -> write_data_ready low from n+1, commit at n+3, write_resp_valid at n+4.
- Reg 0x04 holds 0x11223344; write 0xAABBCCDD with strb 4'b0101 -> read 0x04 returns 0x11BB33DD.
- Write 0x40 (out of range) -> write_resp 2'b10, all registers unchanged. Read 0x40 -> read_data 0, read_resp 2'b10.
- Hold read_data_ready low and write_resp_ready low for 5 cycles -> R and B outputs stable throughout; read_addr_ready, write_addr_ready and write_data_ready stay 0. Release -> each completes in one cycle, readies return the next cycle.
- Assert rst for 1 cycle while in W_RESP and R_DATA -> next edge: all valids and readies 0, registers read back as 0 afterwards, no stale response is issued.
